div_unit: RTL and testbench
===========================

// Module: div_unit
// PURPOSE
//  Multi-cycle restoring divider for the EX stage; executes DIV/DIVU using operands delivered by the ID/EX register.
//  EX drives start_i and holds the pipeline stalled until ready_o; the result goes to HI (remainder) and LO (quotient).
//  A pipeline flush cancels an in-flight division through annul_i.
// PARAMETERS
//  WIDTH   32   operand width; quotient and remainder are WIDTH bits each
// PORTS
//  clk           in   1         clock, rising edge
//  rst           in   1         asynchronous reset, active-high
//  signed_div_i  in   1         1 = DIV (two's complement), 0 = DIVU
//  opdata1_i     in   WIDTH     dividend, sampled only on the accepting edge
//  opdata2_i     in   WIDTH     divisor, sampled only on the accepting edge
//  start_i       in   1         request; EX holds it high until it sees ready_o
//  annul_i       in   1         cancel (flush or exception)
//  result_o      out  2*WIDTH   {remainder, quotient}
//  ready_o       out  1         result valid
// BEHAVIOUR
//  - Reset (async, rst=1): state=FREE, cnt=0, result_o=0, ready_o=0. Reset mid-operation aborts the operation immediately.
//  - All outputs are registered. State machine:
//  - FREE: ready_o=0, result_o=0.
//    - start_i=1 & annul_i=0 & divisor==0 -> BYZERO.
//    - start_i=1 & annul_i=0 & divisor!=0 -> ON. Latch the magnitudes |op1| and |op2| (signed mode), or the raw values,
//      plus sign1 and sign2. Clear the WIDTH+1-bit partial remainder. cnt=0.
//  - BYZERO: next edge -> END with result_o=0, ready_o=1.
//  - ON: if annul_i=1 -> FREE (ready_o=0, result_o=0).
//    - Else if cnt!=WIDTH: one restoring step per edge (shift in the next dividend bit, trial-subtract the divisor,
//      set the quotient bit when the difference is non-negative), then cnt++.
//    - Else (cnt==WIDTH): apply signs -> END, ready_o=1.
//  - Sign fix-up (signed mode only): quotient negated if sign1^sign2; remainder negated if sign1.
//  - END: ready_o=1 and result_o held stable while start_i=1. start_i=0 -> FREE (ready_o=0, result_o=0). annul_i is ignored in END.
//  - Latency: ready_o goes high after the (WIDTH+2)th rising edge from the accepting edge (34 for WIDTH=32).
//    For divide-by-zero it goes high after the 2nd edge.
//  - start_i is ignored outside FREE. Operand changes after acceptance have no effect.
//  - annul_i=1 in FREE blocks acceptance that cycle. annul_i in BYZERO is ignored; BYZERO completes.
//  - Arithmetic: the quotient and remainder wrap modulo 2^WIDTH.
//    Signed MIN/-1 gives quotient 0x80000000, remainder 0. No overflow flag.
//  - The FSM returns to FREE only via the END->FREE path, the ON annul path, or reset.
//    Back-to-back operations need start_i to drop for at least one cycle.
// TESTING
//  1. DIVU 100/7 -> ready_o after 34 edges; result_o={32'd2,32'd14}; stays high while start_i=1; ready_o=0 one edge after start_i=0.
//  2. DIV -7/2 -> {32'hFFFFFFFF,32'hFFFFFFFD}. DIV 7/-2 -> {32'h1,32'hFFFFFFFD}. DIVU 0xFFFFFFFF/2 -> {32'h1,32'h7FFFFFFF}.
//  3. Divisor 0, either mode -> ready_o after 2 edges; result_o=0.
//  4. annul_i pulsed at ON cycle 10 -> FREE; ready_o never rises. A new DIVU 9/3 then gives {0,3} after 34 edges.
//  5. rst asserted mid-ON, asynchronously between edges -> ready_o=0, result_o=0 immediately. A fresh 100/7 completes normally.
//  6. DIV 0x80000000/0xFFFFFFFF -> {0,32'h80000000}. Operands changed during ON -> result unchanged.

Source files
------------

// File: rtl/div_unit.sv
// div_unit: multi-cycle restoring divider for the EX stage (DIV / DIVU).
//   EX raises start_i and stalls until ready_o. The result goes to HI
//   (remainder, upper half) and LO (quotient, lower half). annul_i cancels
//   an in-flight division on a flush.
// Ports:
//   clk, rst            clock (rising edge), async active-high reset
//   signed_div_i        1 = two's complement divide, 0 = unsigned
//   opdata1_i/2_i       dividend / divisor, sampled on the accepting edge only
//   start_i             request, held high until ready_o is seen
//   annul_i             cancel the division in flight
//   result_o            {remainder, quotient}, registered
//   ready_o             result valid, registered
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_FREE, S_BYZERO, S_ON, S_END} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd;   // dividend magnitude, shifted out MSB first
  logic [WIDTH-1:0] dsr;   // divisor magnitude
  logic [WIDTH-1:0] rem;   // partial remainder (always < divisor after a step)
  logic [WIDTH-1:0] quot;
  logic             sign1, sign2;

  // Magnitudes of the incoming operands; -MIN wraps to MIN, which is the
  // correct unsigned magnitude 2^(WIDTH-1).
  logic             neg1, neg2;
  logic [WIDTH-1:0] abs1, abs2;
  assign neg1 = signed_div_i & opdata1_i[WIDTH-1];
  assign neg2 = signed_div_i & opdata2_i[WIDTH-1];
  assign abs1 = neg1 ? -opdata1_i : opdata1_i;
  assign abs2 = neg2 ? -opdata2_i : opdata2_i;

  // One restoring step: the WIDTH+1-bit shifted remainder, trial-subtracted.
  // A clear borrow bit means the difference is non-negative.
  logic [WIDTH:0]   rem_sh, diff;
  logic             q_bit;
  assign rem_sh = {rem, dvd[WIDTH-1]};
  assign diff   = rem_sh - {1'b0, dsr};
  assign q_bit  = ~diff[WIDTH];

  // Sign fix-up: quotient takes sign1^sign2, remainder follows the dividend.
  logic [WIDTH-1:0] q_fix, r_fix;
  assign q_fix = (sign1 ^ sign2) ? -quot : quot;
  assign r_fix = sign1 ? -rem : rem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_FREE;
      cnt      <= '0;
      dvd      <= '0;
      dsr      <= '0;
      rem      <= '0;
      quot     <= '0;
      sign1    <= 1'b0;
      sign2    <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      case (state)
        S_FREE: begin
          ready_o  <= 1'b0;
          result_o <= '0;
          if (start_i && !annul_i) begin
            if (opdata2_i == '0) begin
              state <= S_BYZERO;
            end else begin
              state <= S_ON;
              dvd   <= abs1;
              dsr   <= abs2;
              sign1 <= neg1;
              sign2 <= neg2;
              rem   <= '0;
              quot  <= '0;
              cnt   <= '0;
            end
          end
        end
        S_BYZERO: begin
          state    <= S_END;
          result_o <= '0;
          ready_o  <= 1'b1;
        end
        S_ON: begin
          if (annul_i) begin
            state    <= S_FREE;
            result_o <= '0;
            ready_o  <= 1'b0;
          end else if (cnt != CW'(WIDTH)) begin
            rem  <= q_bit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
            quot <= {quot[WIDTH-2:0], q_bit};
            dvd  <= {dvd[WIDTH-2:0], 1'b0};
            cnt  <= cnt + 1'b1;
          end else begin
            state    <= S_END;
            result_o <= {r_fix, q_fix};
            ready_o  <= 1'b1;
          end
        end
        S_END: begin
          // Hold the result while EX keeps start_i up; annul_i has no effect.
          if (!start_i) begin
            state    <= S_FREE;
            result_o <= '0;
            ready_o  <= 1'b0;
          end
        end
        default: state <= S_FREE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        signed_div_i = 1'b0;
  logic [31:0] opdata1_i = '0;
  logic [31:0] opdata2_i = '0;
  logic        start_i = 1'b0;
  logic        annul_i = 1'b0;
  logic [63:0] result_o;
  logic        ready_o;

  int checks = 0;
  int errors = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
    .start_i(start_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain integer division, truncating toward zero, wrapped to 32 bits.
  function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [31:0] uq, ur;
    if (b == 0) return 64'd0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
    end
    uq = a / b;
    ur = a % b;
    return {ur, uq};
  endfunction

  // One full handshake: present, wait for ready (bounded), check latency,
  // result, hold while start_i stays high, then drop start_i.
  task automatic run_op(input string tag, input bit sgn, input logic [31:0] a,
                        input logic [31:0] b, input bit scramble, input bit pre_annul);
    logic [63:0] exp;
    int n, lat;
    exp = model(sgn, a, b);
    lat = (b == 0) ? 2 : 34;
    @(negedge clk);
    signed_div_i = sgn; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
    if (pre_annul) begin
      annul_i = 1'b1;       // blocks acceptance on this edge
      @(negedge clk);
      annul_i = 1'b0;
    end
    @(posedge clk); n = 1; #1;
    while (!ready_o && n < 100) begin
      if (scramble) begin opdata1_i = $urandom; opdata2_i = $urandom; end
      @(posedge clk); n++; #1;
    end
    chk({tag, " latency"}, 64'(n), 64'(lat));
    @(negedge clk);
    chk({tag, " result"}, result_o, exp);
    repeat (3) begin
      if (scramble) begin opdata1_i = $urandom; opdata2_i = $urandom; annul_i = 1'b1; end
      @(negedge clk);
    end
    annul_i = 1'b0;
    chk({tag, " hold rdy"}, 64'(ready_o), 64'd1);
    chk({tag, " hold res"}, result_o, exp);
    start_i = 1'b0;
    @(posedge clk); #1;
    chk({tag, " drop"}, {63'd0, ready_o} | result_o, 64'd0);
  endtask

  initial begin
    bit quiet;
    #2;
    chk("reset rdy", 64'(ready_o), 64'd0);
    chk("reset res", result_o, 64'd0);
    @(negedge clk); rst = 1'b0;

    // Directed cases
    run_op("divu 100/7", 0, 32'd100, 32'd7, 0, 0);
    run_op("div -7/2",   1, 32'hFFFFFFF9, 32'd2, 0, 0);
    run_op("div 7/-2",   1, 32'd7, 32'hFFFFFFFE, 0, 0);
    run_op("divu max/2", 0, 32'hFFFFFFFF, 32'd2, 0, 0);
    run_op("divu /0",    0, 32'd55, 32'd0, 0, 0);
    run_op("div /0",     1, 32'h80000000, 32'd0, 0, 0);
    run_op("div min/-1", 1, 32'h80000000, 32'hFFFFFFFF, 1, 0);
    run_op("scramble",   1, 32'h12345678, 32'hFFFFF001, 1, 0);
    run_op("free annul", 0, 32'd1000, 32'd10, 0, 1);

    // Annul at ON cycle 10: ready never rises, then a fresh op works
    @(negedge clk);
    signed_div_i = 0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk); annul_i = 1'b1;
    @(negedge clk); annul_i = 1'b0; start_i = 1'b0;
    quiet = 1'b1;
    repeat (40) begin @(negedge clk); if (ready_o) quiet = 1'b0; end
    chk("annul quiet", 64'(quiet), 64'd1);
    run_op("divu 9/3", 0, 32'd9, 32'd3, 0, 0);

    // Async reset mid-ON and while a result is held
    @(negedge clk);
    opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    repeat (20) @(posedge clk);
    start_i = 1'b0;
    #3 rst = 1'b1; #1;
    chk("rst on", {63'd0, ready_o} | result_o, 64'd0);
    @(negedge clk); rst = 1'b0;
    quiet = 1'b1;
    repeat (40) begin @(negedge clk); if (ready_o) quiet = 1'b0; end
    chk("rst quiet", 64'(quiet), 64'd1);
    @(negedge clk);
    opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    repeat (34) @(posedge clk);
    #3;
    chk("end rdy", 64'(ready_o), 64'd1);
    rst = 1'b1; #1;
    chk("rst end", {63'd0, ready_o} | result_o, 64'd0);
    start_i = 1'b0;
    @(negedge clk); rst = 1'b0;
    run_op("after rst", 0, 32'd100, 32'd7, 0, 0);

    // Randomized operations
    for (int i = 0; i < 150; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: b = -$urandom_range(1, 15);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) a = 32'h80000000;
      run_op("rand", 1'($urandom_range(0, 1)), a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
